lcd_frame_seq: RTL
==================

LCD_FRAME_SEQ -- requirements
Module: lcd_frame_seq

Interface
Parameters:
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, LCD slave base address (instruction at +0x00, data at +0x04).
REQ-002 SHALL have parameter PWR_WAIT_CYCLES, default 2_000_000, power-on delay (40 ms at 50 MHz).
REQ-003 SHALL have parameter CMD_WAIT_CYCLES, default 2_000, post-transfer delay (40 us).
REQ-004 SHALL have parameter CLR_WAIT_CYCLES, default 82_000, post-clear (0x01) delay (1.64 ms).

Ports:
REQ-005 SHALL have ports:
- HCLK  in  1  clock; one clock domain.
- HRESETn  in  1  asynchronous, active-low reset.
- HADDR  out  32  AHB-Lite master address.
- HTRANS  out  2  IDLE 2'b00 or NONSEQ 2'b10 only.
- HWRITE  out  1  constant 1.
- HSIZE  out  3  constant 3'b010.
- HWDATA  out  32  {24'h0, byte}.
- HREADY  in  1  bus ready (slave HREADYOUT).
- buf_we  in  1  frame-buffer write strobe.
- buf_addr  in  5  character index 0-31 (0-15 line 1, 16-31 line 2).
- buf_wdata  in  8  character code.
- refresh_req  in  1  single-cycle pulse; request full-screen rewrite.
- init_done  out  1  init sequence complete.
- busy  out  1  transfer, delay or pending work in progress.

Function
REQ-006 SHALL hold a 32x8 frame buffer written on posedge HCLK when buf_we=1, in any state; it SHALL reset to 8'h20.
REQ-007 SHALL use states PWR_WAIT, ADDR, DATA, DELAY, IDLE; reset enters PWR_WAIT.
REQ-008 PWR_WAIT SHALL count PWR_WAIT_CYCLES cycles, then go to ADDR with the first init op.
REQ-009 Init ops SHALL be instruction writes, in order: 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01.
REQ-010 Refresh ops SHALL be, in order:
- instruction 0x80;
- data buf[0..15];
- instruction 0xC0;
- data buf[16..31].
  That is 34 transfers.
REQ-011 Op address SHALL be BASE_ADDR+0x00 for instructions and BASE_ADDR+0x04 for data.
REQ-012 ADDR SHALL drive HTRANS=NONSEQ and HADDR, and hold both until HREADY=1 is sampled; then go to DATA.
REQ-013 DATA SHALL drive HTRANS=IDLE and HWDATA, and hold HWDATA until HREADY=1 is sampled; then go to DELAY.
REQ-014 DELAY SHALL wait CLR_WAIT_CYCLES after byte 0x01 and CMD_WAIT_CYCLES otherwise, then:
- issue the next op (ADDR); or
- if the sequence is finished, go to IDLE.
REQ-015 Data bytes SHALL be read from the buffer in the ADDR cycle the transfer is accepted; buffer writes after that cycle affect only later refreshes.
REQ-016 init_done SHALL rise on entry to IDLE after the init sequence and stay 1 until reset.
REQ-017 A refresh_req in any state SHALL set a pending flag; IDLE with pending=1 SHALL clear the flag and start a refresh next cycle.
REQ-018 Multiple requests while pending SHALL merge into one refresh.
REQ-019 After init completes, one refresh SHALL run automatically (pending set at init end).
REQ-020 busy SHALL equal (state!=IDLE) | pending.
REQ-021 Outside ADDR, HTRANS SHALL be IDLE.
REQ-022 Counters SHALL be sized $clog2(max wait+1) bits; a delay of N SHALL hold DELAY exactly N cycles.
REQ-023 A zero-wait delay SHALL spend exactly 1 cycle in DELAY.

Reset
REQ-024 On HRESETn=0, at any time, SHALL:
- set HTRANS=IDLE, HADDR=BASE_ADDR, HWDATA=0;
- clear init_done, pending and counters;
- set busy=1 and state=PWR_WAIT.
REQ-025 Reset mid-transfer SHALL abandon the transfer without completing its data phase; after reset the full init sequence restarts.

Verification
REQ-026 Benches SHALL use PWR=10, CMD=3, CLR=5 with an LCD slave model stalling HREADY 4 cycles per transfer, and SHALL cover:
- Reset release -> after 10 cycles: instruction writes 33,32,28,0C,06,01 at +0x00, 5 cycles after 01, then init_done=1, then auto refresh of 34 transfers of 8'h20 (80 and C0 to +0x00).
- Buffer "HELLO" at 0-4 and 'W' at 31, then refresh_req -> 80,'H','E','L','L','O',20x11,C0,20x15,'W'.
- Three refresh_req pulses during a refresh -> exactly one further refresh; busy=0 afterwards.
- buf_we to index 20 while index 18 is in flight -> the new byte appears at index 20 in the same refresh.
- HRESETn low during a DATA stall -> HTRANS=IDLE immediately, init_done=0; full init re-runs after release.
- HREADY held low 20 cycles in ADDR -> HADDR/HTRANS stable throughout; single transfer issued.

Source files
------------

// File: rtl/lcd_frame_seq.sv
// AHB-Lite master that powers up an HD44780-style LCD and rewrites a 32-char frame buffer on request.
// One transfer at a time (ADDR, DATA, DELAY); every phase holds while HREADY is low, and refresh requests merge while pending.
module lcd_frame_seq #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned PWR_WAIT_CYCLES = 2_000_000,
  parameter int unsigned CMD_WAIT_CYCLES = 2_000,
  parameter int unsigned CLR_WAIT_CYCLES = 82_000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        buf_we,
  input  logic [4:0]  buf_addr,
  input  logic [7:0]  buf_wdata,
  input  logic        refresh_req,
  output logic        init_done,
  output logic        busy
);

  localparam int unsigned MAX_PC = (PWR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? PWR_WAIT_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned MAXW   = (MAX_PC > CLR_WAIT_CYCLES) ? MAX_PC : CLR_WAIT_CYCLES;
  localparam int unsigned CW     = (MAXW == 0) ? 1 : $clog2(MAXW + 1);

  typedef enum logic [2:0] {PWR_WAIT, ADDR, DATA, DELAY, IDLE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_idx_q, op_idx_d;
  logic          init_q, init_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    fb_q [32];

  logic [7:0]    op_byte;
  logic          op_is_data;
  logic          op_last;
  logic [4:0]    rd_idx;
  logic          pwr_done;
  logic          dly_done;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 32; i++) fb_q[i] <= 8'h20;
    end else if (buf_we) begin
      fb_q[buf_addr] <= buf_wdata;
    end
  end

  // Refresh op map: 0 -> 0x80, 1..16 -> buf[0..15], 17 -> 0xC0, 18..33 -> buf[16..31].
  always_comb begin
    op_byte    = 8'h00;
    op_is_data = 1'b0;
    op_last    = 1'b0;
    rd_idx     = 5'd0;
    if (init_q) begin
      op_last = (op_idx_q == 6'd5);
      case (op_idx_q)
        6'd0:    op_byte = 8'h33;
        6'd1:    op_byte = 8'h32;
        6'd2:    op_byte = 8'h28;
        6'd3:    op_byte = 8'h0C;
        6'd4:    op_byte = 8'h06;
        default: op_byte = 8'h01;
      endcase
    end else begin
      op_last = (op_idx_q == 6'd33);
      if (op_idx_q == 6'd0) begin
        op_byte = 8'h80;
      end else if (op_idx_q == 6'd17) begin
        op_byte = 8'hC0;
      end else begin
        op_is_data = 1'b1;
        rd_idx     = (op_idx_q < 6'd17) ? op_idx_q[4:0] - 5'd1 : op_idx_q[4:0] - 5'd2;
        op_byte    = fb_q[rd_idx];
      end
    end
  end

  assign pwr_done = (32'(cnt_q) + 32'd1 >= PWR_WAIT_CYCLES);
  assign dly_done = (32'(cnt_q) + 32'd1 >= ((wdat_q == 8'h01) ? CLR_WAIT_CYCLES : CMD_WAIT_CYCLES));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= PWR_WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_idx_d = op_idx_q;
    init_d   = init_q;
    done_d   = done_q;
    wdat_d   = wdat_q;
    pend_d   = pend_q | refresh_req;
    unique case (state_q)
      PWR_WAIT: begin
        if (pwr_done) begin
          state_d = ADDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ADDR: begin
        // Data byte is captured on the accepting edge; later buffer writes miss this refresh.
        if (HREADY) begin
          state_d = DATA;
          wdat_d  = op_byte;
        end
      end
      DATA: begin
        if (HREADY) begin
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (dly_done) begin
          cnt_d = '0;
          if (op_last) begin
            state_d  = IDLE;
            op_idx_d = '0;
            if (init_q) begin
              init_d = 1'b0;
              done_d = 1'b1;
              pend_d = 1'b1;
            end
          end else begin
            state_d  = ADDR;
            op_idx_d = op_idx_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        // A request landing in the same cycle merges into the refresh being started.
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = ADDR;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q    <= '0;
      op_idx_q <= '0;
      init_q   <= 1'b1;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      wdat_q   <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      op_idx_q <= op_idx_d;
      init_q   <= init_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      wdat_q   <= wdat_d;
    end
  end

  always_comb begin
    HTRANS = (state_q == ADDR) ? 2'b10 : 2'b00;
    HADDR  = op_is_data ? (BASE_ADDR + 32'h4) : BASE_ADDR;
    busy   = (state_q != IDLE) | pend_q;
  end

  assign HWRITE    = 1'b1;
  assign HSIZE     = 3'b010;
  assign HWDATA    = {24'h0, wdat_q};
  assign init_done = done_q;

endmodule
